monost_sched: RTL and testbench

//   Shares one monostable timer between N trigger channels.
//   - Rising edges on trig[i] are latched as pending requests.
//   - Pending requests are granted round-robin, one at a time.
//   - The granted channel's active-low output stays low for WAIT_TIME cycles.
//   - Sits between raw trigger sources (buttons, CPU strobes) and the board LEDs.
//   - Replaces N independent 24-bit monostable counters with a single shared counter.

---
 rtl/monost_sched.sv | 151 +++++++++++++++
 tb/tb_monost_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/monost_sched.sv
// One shared monostable timer serving N rising-edge trigger channels in round-robin order.
// Optional build macro MONOST_RETRIG_EN: a re-trigger of the running channel extends its pulse.
module monost_sched #(
    parameter int unsigned N          = 4,
    parameter int unsigned WAIT_TIME  = 3500000,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned CNT_W      = 24,
    localparam int unsigned ID_W      = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    trig,
    output logic [N-1:0]    led_n,
    output logic            busy,
    output logic [ID_W-1:0] active_id,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(WAIT_TIME - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [N-1:0]     ONE      = N'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   active_id_d;
    logic [N-1:0]      pending_q, pending_d;
    logic [N-1:0]      trig_q;
    logic [N-1:0]      rise;
    logic [N-1:0]      retrig_vec;
    logic              retrig_hit;
    logic [N-1:0]      grant_vec;
    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   winner;
    logic              found;
    logic [N-1:0]      led_n_d;
    logic              busy_d;
    logic              done_d;

    // Round-robin search: first pending channel after rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = ID_W'((32'(rr_ptr_q) + i) % N);
            if (!found && pending_q[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Edge detect and pending bookkeeping; a new rise wins over a same-cycle grant clear.
    always_comb begin
        rise = trig & ~trig_q;
`ifdef MONOST_RETRIG_EN
        retrig_vec = (state_q == RUN) ? (rise & (ONE << active_id)) : '0;
`else
        retrig_vec = '0;
`endif
        retrig_hit = |retrig_vec;
        pending_d  = (pending_q & ~grant_vec) | (rise & ~retrig_vec);
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        active_id_d = active_id;
        grant_vec   = '0;
        case (state_q)
            IDLE: begin
                if (en && found) begin
                    state_d     = RUN;
                    cnt_d       = '0;
                    rr_ptr_d    = winner;
                    active_id_d = winner;
                    grant_vec   = ONE << winner;
                end
            end
            RUN: begin
                if (retrig_hit) begin
                    cnt_d = '0;
                end else if (cnt_q == RUN_LAST) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from next-state values so the registered outputs track the state register.
    always_comb begin
        led_n_d = '1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (state_d == RUN) begin
            led_n_d = ~(ONE << active_id_d);
            done_d  = (cnt_d == RUN_LAST);
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_ptr_q  <= ID_W'(N - 1);
            active_id <= '0;
            pending_q <= '0;
            trig_q    <= '0;
            led_n     <= '1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            active_id <= active_id_d;
            pending_q <= pending_d;
            trig_q    <= trig;
            led_n     <= led_n_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_monost_sched.sv
// Bench for monost_sched: vector table of simultaneous triggers plus hand-written corner sequences,
// with observed pulses checked against an expected-pulse queue.
module tb_monost_sched;

    localparam int N   = 4;
    localparam int WT  = 8;
    localparam int GAP = 2;
    localparam int PERIOD = WT + GAP + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] trig;
    logic [3:0] led_n;
    logic       busy;
    logic       done;
    logic [1:0] active_id;

    monost_sched #(
        .N(N), .WAIT_TIME(WT), .GAP_CYCLES(GAP), .CNT_W(24)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .trig(trig),
        .led_n(led_n), .busy(busy), .active_id(active_id), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int ch;
        int start;
        int len;
    } pulse_t;
    pulse_t sb[$];
    pulse_t got;

    task automatic expect_pulse(input int ch, input int start, input int len);
        pulse_t p;
        p.ch = ch; p.start = start; p.len = len;
        sb.push_back(p);
    endtask

    // Pulse monitor: measures each low stretch of led_n and compares it with the queue head.
    logic [3:0] prev = 4'hF;
    int         st[4];
    int         last_done = -1;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev = 4'hF;
        end else begin
            if (done) last_done = cyc;
            for (int c = 0; c < 4; c++) begin
                if (!led_n[c] && prev[c]) begin
                    st[c] = cyc;
                end else if (led_n[c] && !prev[c]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: ch %0d start %0d len %0d, none expected", c, st[c], cyc - st[c]);
                    end else begin
                        got = sb.pop_front();
                        chk("pulse_ch", c, got.ch);
                        chk("pulse_start", st[c], got.start);
                        chk("pulse_len", cyc - st[c], got.len);
                        chk("done_on_last_cycle", last_done, cyc - 1);
                        chk("active_id_hold", int'(active_id), c);
                    end
                end
            end
            prev = led_n;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_trig(input logic [3:0] m);
        trig = m;
        step(1);
        trig = 4'b0000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    typedef struct packed {
        logic [3:0]      trig;
        logic [2:0]      n;
        logic [3:0][1:0] order;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] t, input int n,
                                input int o0, input int o1, input int o2, input int o3);
        vec_t v;
        v.trig     = t;
        v.n        = 3'(n);
        v.order[0] = 2'(o0);
        v.order[1] = 2'(o1);
        v.order[2] = 2'(o2);
        v.order[3] = 2'(o3);
        return v;
    endfunction

    vec_t tbl[5];
    int   c0;
    int   s0;

    initial begin
        // Round-robin vectors applied back to back from reset (pointer starts at 3).
        tbl[0] = mk(4'b1011, 3, 0, 1, 3, 0);
        tbl[1] = mk(4'b0110, 2, 1, 2, 0, 0);
        tbl[2] = mk(4'b1001, 2, 3, 0, 0, 0);
        tbl[3] = mk(4'b0100, 1, 2, 0, 0, 0);
        tbl[4] = mk(4'b1111, 4, 3, 0, 1, 2);

        rst_n = 1'b0;
        en    = 1'b1;
        trig  = 4'b0000;
        step(3);
        chk("rst_led_n", int'(led_n), 15);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_active_id", int'(active_id), 0);
        rst_n = 1'b1;
        step(2);

        // Single trigger on channel 2 with explicit cycle-by-cycle checks.
        c0 = cyc;
        expect_pulse(2, c0 + 2, WT);
        pulse_trig(4'b0100);
        chk("single_led_before_grant", int'(led_n), 15);
        chk("single_busy_before_grant", int'(busy), 0);
        step(1);
        chk("single_led_run", int'(led_n), 4'b1011);
        chk("single_busy_run", int'(busy), 1);
        chk("single_active_id", int'(active_id), 2);
        chk("single_done_early", int'(done), 0);
        step(7);
        chk("single_done_last", int'(done), 1);
        chk("single_led_last", int'(led_n), 4'b1011);
        step(1);
        chk("single_led_after", int'(led_n), 15);
        chk("single_done_after", int'(done), 0);
        chk("single_busy_gap0", int'(busy), 1);
        step(1);
        chk("single_busy_gap1", int'(busy), 1);
        step(1);
        chk("single_busy_idle", int'(busy), 0);
        step(5);
        chk("single_drain", sb.size(), 0);

        do_reset();
        for (int v = 0; v < 5; v++) begin
            c0 = cyc;
            for (int k = 0; k < int'(tbl[v].n); k++)
                expect_pulse(int'(tbl[v].order[k]), c0 + 2 + PERIOD * k, WT);
            pulse_trig(tbl[v].trig);
            step(50);
            chk("vec_drain", sb.size(), 0);
        end

        // en low: request is held, granted one cycle after en rises.
        en = 1'b0;
        pulse_trig(4'b0010);
        step(20);
        chk("en0_led_n", int'(led_n), 15);
        chk("en0_busy", int'(busy), 0);
        c0 = cyc;
        expect_pulse(1, c0 + 1, WT);
        en = 1'b1;
        step(1);
        chk("en1_led_n", int'(led_n), 4'b1101);
        step(20);
        chk("en_drain", sb.size(), 0);

        // Re-trigger of channel 0 during its own pulse (rise sampled on the sixth RUN edge).
        c0 = cyc;
        s0 = c0 + 2;
`ifdef MONOST_RETRIG_EN
        expect_pulse(0, s0, 5 + WT);
`else
        expect_pulse(0, s0, WT);
        expect_pulse(0, s0 + PERIOD, WT);
`endif
        pulse_trig(4'b0001);
        step(5);
        pulse_trig(4'b0001);
        step(40);
        chk("retrig_drain", sb.size(), 0);

        // Reset in the middle of a channel 3 pulse with channel 2 pending.
        pulse_trig(4'b1000);
        step(1);
        pulse_trig(4'b0100);
        step(2);
        chk("midrst_led_before", int'(led_n), 4'b0111);
        chk("midrst_id_before", int'(active_id), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_led_n", int'(led_n), 15);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_active_id", int'(active_id), 0);
        step(2);
        rst_n = 1'b1;
        step(30);
        chk("midrst_led_after", int'(led_n), 15);
        chk("midrst_busy_after", int'(busy), 0);
        chk("final_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
